// File: rtl/control_unit_if.sv
// Signal bundle between the sequencer and its surroundings: run/opcode/acc_sign
// in, control word, ALU select and debug/status out.
interface control_unit_if #(
   parameter int CNT_W = 16
);
   logic             run;
   logic [7:0]       opcode;
   logic             acc_sign;
   logic [15:0]      c;
   logic [7:0]       alu_fn;
   logic             halted;
   logic [CNT_W-1:0] instr_cnt;
   logic [3:0]       state;

   modport master (
      output run, opcode, acc_sign,
      input  c, alu_fn, halted, instr_cnt, state
   );

   modport slave (
      input  run, opcode, acc_sign,
      output c, alu_fn, halted, instr_cnt, state
   );
endinterface

// File: rtl/control_unit.sv
// Microsequencer for the 16-bit accumulator CPU: fetch/decode/execute FSM that
// emits the datapath control word and ALU select for each state.
module control_unit #(
   parameter int CNT_W = 16
) (
   input logic           clk,
   input logic           rst,
   control_unit_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_F1   = 4'd1,
      S_F2   = 4'd2,
      S_F3   = 4'd3,
      S_DEC  = 4'd4,
      S_E1   = 4'd5,
      S_E2   = 4'd6,
      S_E3   = 4'd7,
      S_E4   = 4'd8,
      S_HALT = 4'd9
   } state_e;

   localparam logic [7:0] OP_STORE  = 8'h01;
   localparam logic [7:0] OP_LOAD   = 8'h02;
   localparam logic [7:0] OP_JMPGEZ = 8'h05;
   localparam logic [7:0] OP_JMP    = 8'h06;
   localparam logic [7:0] OP_HALT   = 8'h07;
   localparam logic [7:0] OP_ZXMEM  = 8'h0C;

   localparam logic [15:0] C0  = 16'h0001;
   localparam logic [15:0] C2  = 16'h0004;
   localparam logic [15:0] C3  = 16'h0008;
   localparam logic [15:0] C4  = 16'h0010;
   localparam logic [15:0] C5  = 16'h0020;
   localparam logic [15:0] C6  = 16'h0040;
   localparam logic [15:0] C7  = 16'h0080;
   localparam logic [15:0] C8  = 16'h0100;
   localparam logic [15:0] C9  = 16'h0200;
   localparam logic [15:0] C11 = 16'h0800;
   localparam logic [15:0] C12 = 16'h1000;
   localparam logic [15:0] C14 = 16'h4000;
   localparam logic [15:0] C15 = 16'h8000;

   function automatic logic is_mem_op(input logic [7:0] op);
      return ((op >= 8'h01) && (op <= 8'h04)) || ((op >= 8'h08) && (op <= 8'h0C));
   endfunction

   function automatic logic is_shift_op(input logic [7:0] op);
      return (op >= 8'h0D) && (op <= 8'h0F);
   endfunction

   function automatic logic is_exec_op(input logic [7:0] op);
      return is_mem_op(op) || is_shift_op(op) || (op == OP_JMPGEZ) || (op == OP_JMP);
   endfunction

   state_e           state_q, state_d;
   logic [7:0]       opc_q, opc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             halted_q, halted_d;
   state_e           eoi_state;
   logic [15:0]      ctrl_word;
   logic [7:0]       alu_sel;

   // run is only looked at here and in IDLE, so dropping it mid-instruction
   // lets the current instruction finish.
   assign eoi_state = bus.run ? S_F1 : S_IDLE;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path through the case leaves it unassigned (which would infer a latch).
      state_d  = state_q;
      opc_d    = opc_q;
      cnt_d    = cnt_q;
      halted_d = halted_q;
      case (state_q)
         S_IDLE: state_d = bus.run ? S_F1 : S_IDLE;
         S_F1:   state_d = S_F2;
         S_F2:   state_d = S_F3;
         S_F3:   state_d = S_DEC;
         S_DEC: begin
            opc_d = bus.opcode;
            cnt_d = cnt_q + CNT_W'(1);
            if (bus.opcode == OP_HALT) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
            end else if (is_exec_op(bus.opcode)) begin
               state_d = S_E1;
            end else begin
               state_d = eoi_state;
            end
         end
         S_E1:   state_d = is_mem_op(opc_q) ? S_E2 : eoi_state;
         S_E2:   state_d = S_E3;
         S_E3:   state_d = (opc_q == OP_STORE) ? eoi_state : S_E4;
         S_E4:   state_d = eoi_state;
         S_HALT: state_d = S_HALT;
         default: begin
            state_d  = S_IDLE;
            halted_d = 1'b0;
         end
      endcase
   end

   // Moore decode of the current state and the opcode captured in DEC; only the
   // JMPGEZ execute cycle looks at live acc_sign.
   always_comb begin
      ctrl_word = '0;
      alu_sel   = '0;
      case (state_q)
         S_F1: ctrl_word = C2;
         S_F2: ctrl_word = C0 | C5 | C15;
         S_F3: ctrl_word = C4;
         S_E1: begin
            if (is_mem_op(opc_q)) begin
               ctrl_word = C8;
            end else if (opc_q == OP_JMP) begin
               ctrl_word = C3;
            end else if (opc_q == OP_JMPGEZ) begin
               ctrl_word = bus.acc_sign ? 16'h0000 : C3;
            end else if (is_shift_op(opc_q)) begin
               ctrl_word = C9 | C14;
               alu_sel   = opc_q;
            end
         end
         S_E2: ctrl_word = (opc_q == OP_STORE) ? C11 : (C0 | C5);
         S_E3: ctrl_word = (opc_q == OP_STORE) ? (C0 | C12) : C6;
         S_E4: begin
            ctrl_word = C9;
            if ((opc_q == OP_LOAD) || (opc_q == OP_ZXMEM)) ctrl_word = C9 | C7;
            alu_sel = opc_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         opc_q    <= '0;
         cnt_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every register
         // samples its pre-edge value regardless of statement order.
         state_q  <= state_d;
         opc_q    <= opc_d;
         cnt_q    <= cnt_d;
         halted_q <= halted_d;
      end
   end

   assign bus.c         = ctrl_word;
   assign bus.alu_fn    = alu_sel;
   assign bus.halted    = halted_q;
   assign bus.instr_cnt = cnt_q;
   assign bus.state     = state_q;

   a_no_pc_conflict: assert property (@(posedge clk) disable iff (!rst)
      !(ctrl_word[3] && ctrl_word[15]));

   a_write_only_in_store: assert property (@(posedge clk) disable iff (!rst)
      ctrl_word[12] |-> ((state_q == S_E3) && (opc_q == OP_STORE)));

   a_halt_is_terminal: assert property (@(posedge clk) disable iff (!rst)
      (state_q == S_HALT) |=> ((state_q == S_HALT) && halted_q && $stable(cnt_q)));

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, hand-written
// reset/HALT/wrap sequences and randomized instructions against a sequence model.
module tb_control_unit;

   logic       clk      = 1'b0;
   logic       rst      = 1'b0;
   logic       run      = 1'b0;
   logic       acc_sign = 1'b0;
   logic [7:0] opcode   = 8'h00;

   control_unit_if #(.CNT_W(16)) bus ();
   control_unit_if #(.CNT_W(4))  bus4 ();

   assign bus.run       = run;
   assign bus.opcode    = opcode;
   assign bus.acc_sign  = acc_sign;
   assign bus4.run      = run;
   assign bus4.opcode   = opcode;
   assign bus4.acc_sign = acc_sign;

   control_unit #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
   control_unit #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

   always #5 clk = ~clk;

   int checks       = 0;
   int failures     = 0;
   int c12_seen     = 0;
   int overlap_seen = 0;
   int stores_m     = 0;
   int cnt_m        = 0;

   // One instruction: inputs plus the expected c/alu_fn word for each cycle from F1.
   typedef struct packed {
      logic [7:0]        op;
      logic              sign;
      logic [3:0]        len;
      logic [0:7][15:0]  cw;
      logic [0:7][7:0]   af;
   } vec_t;

   vec_t vecs [12];

   always @(negedge clk) begin
      if (bus.c[12]) c12_seen++;
      if (bus.c[3] && bus.c[15]) overlap_seen++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected cycle sequence for one instruction, from the instruction rules.
   function automatic vec_t model(input logic [7:0] op, input logic sign);
      vec_t v;
      logic mem;
      v       = '0;
      v.op    = op;
      v.sign  = sign;
      v.cw[0] = 16'h0004;
      v.cw[1] = 16'h8021;
      v.cw[2] = 16'h0010;
      v.cw[3] = 16'h0000;
      v.len   = 4'd4;
      mem = ((op >= 8'h01) && (op <= 8'h04)) || ((op >= 8'h08) && (op <= 8'h0C));
      if (op == 8'h01) begin
         v.cw[4] = 16'h0100;
         v.cw[5] = 16'h0800;
         v.cw[6] = 16'h1001;
         v.len   = 4'd7;
      end else if (mem) begin
         v.cw[4] = 16'h0100;
         v.cw[5] = 16'h0021;
         v.cw[6] = 16'h0040;
         v.cw[7] = ((op == 8'h02) || (op == 8'h0C)) ? 16'h0280 : 16'h0200;
         v.af[7] = op;
         v.len   = 4'd8;
      end else if (op == 8'h06) begin
         v.cw[4] = 16'h0008;
         v.len   = 4'd5;
      end else if (op == 8'h05) begin
         v.cw[4] = sign ? 16'h0000 : 16'h0008;
         v.len   = 4'd5;
      end else if ((op >= 8'h0D) && (op <= 8'h0F)) begin
         v.cw[4] = 16'h4200;
         v.af[4] = op;
         v.len   = 4'd5;
      end
      return v;
   endfunction

   // Precondition: DUT is in F1. Postcondition: DUT is in F1 again.
   task automatic exec(input vec_t v, input logic final_run, input string tag);
      opcode   = v.op;
      acc_sign = v.sign;
      for (int i = 0; i < int'(v.len); i++) begin
         run = (i == int'(v.len) - 1) ? final_run : 1'($urandom);
         check($sformatf("%s c[%0d]", tag, i), 32'(bus.c), 32'(v.cw[i]));
         check($sformatf("%s alu_fn[%0d]", tag, i), 32'(bus.alu_fn), 32'(v.af[i]));
         check($sformatf("%s halted[%0d]", tag, i), 32'(bus.halted), 32'd0);
         tick();
      end
      cnt_m++;
      if (v.op == 8'h01) stores_m++;
      check($sformatf("%s instr_cnt", tag), 32'(bus.instr_cnt), 32'(cnt_m % 65536));
      check($sformatf("%s instr_cnt w4", tag), 32'(bus4.instr_cnt), 32'(cnt_m % 16));
      if (!final_run) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("%s idle c", tag), 32'(bus.c), 32'd0);
            tick();
         end
         run = 1'b1;
         tick();
      end
   endtask

   initial begin
      logic [7:0] op;
      vec_t       v;

      vecs[0]  = '{op: 8'h03, sign: 1'b0, len: 4'd8,
                   cw: {16'h0004, 16'h8021, 16'h0010, 16'h0000, 16'h0100, 16'h0021, 16'h0040, 16'h0200},
                   af: 64'h00000000_00000003};
      vecs[1]  = '{op: 8'h01, sign: 1'b0, len: 4'd7,
                   cw: {16'h0004, 16'h8021, 16'h0010, 16'h0000, 16'h0100, 16'h0800, 16'h1001, 16'h0000},
                   af: 64'h0};
      vecs[2]  = '{op: 8'h02, sign: 1'b1, len: 4'd8,
                   cw: {16'h0004, 16'h8021, 16'h0010, 16'h0000, 16'h0100, 16'h0021, 16'h0040, 16'h0280},
                   af: 64'h00000000_00000002};
      vecs[3]  = '{op: 8'h0C, sign: 1'b0, len: 4'd8,
                   cw: {16'h0004, 16'h8021, 16'h0010, 16'h0000, 16'h0100, 16'h0021, 16'h0040, 16'h0280},
                   af: 64'h00000000_0000000C};
      vecs[4]  = '{op: 8'h08, sign: 1'b0, len: 4'd8,
                   cw: {16'h0004, 16'h8021, 16'h0010, 16'h0000, 16'h0100, 16'h0021, 16'h0040, 16'h0200},
                   af: 64'h00000000_00000008};
      vecs[5]  = '{op: 8'h05, sign: 1'b0, len: 4'd5,
                   cw: {16'h0004, 16'h8021, 16'h0010, 16'h0000, 16'h0008, 16'h0000, 16'h0000, 16'h0000},
                   af: 64'h0};
      vecs[6]  = '{op: 8'h05, sign: 1'b1, len: 4'd5,
                   cw: {16'h0004, 16'h8021, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                   af: 64'h0};
      vecs[7]  = '{op: 8'h06, sign: 1'b1, len: 4'd5,
                   cw: {16'h0004, 16'h8021, 16'h0010, 16'h0000, 16'h0008, 16'h0000, 16'h0000, 16'h0000},
                   af: 64'h0};
      vecs[8]  = '{op: 8'h0D, sign: 1'b0, len: 4'd5,
                   cw: {16'h0004, 16'h8021, 16'h0010, 16'h0000, 16'h4200, 16'h0000, 16'h0000, 16'h0000},
                   af: 64'h00000000_0D000000};
      vecs[9]  = '{op: 8'h0F, sign: 1'b1, len: 4'd5,
                   cw: {16'h0004, 16'h8021, 16'h0010, 16'h0000, 16'h4200, 16'h0000, 16'h0000, 16'h0000},
                   af: 64'h00000000_0F000000};
      vecs[10] = '{op: 8'h00, sign: 1'b0, len: 4'd4,
                   cw: {16'h0004, 16'h8021, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                   af: 64'h0};
      vecs[11] = '{op: 8'h2A, sign: 1'b0, len: 4'd4,
                   cw: {16'h0004, 16'h8021, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                   af: 64'h0};

      // Held in reset with run high: nothing may move.
      run    = 1'b1;
      opcode = 8'h03;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("reset c", 32'(bus.c), 32'd0);
         check("reset alu_fn", 32'(bus.alu_fn), 32'd0);
         check("reset halted", 32'(bus.halted), 32'd0);
         check("reset instr_cnt", 32'(bus.instr_cnt), 32'd0);
         check("reset instr_cnt w4", 32'(bus4.instr_cnt), 32'd0);
      end
      rst = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) begin
         exec(vecs[i], 1'(i % 2), $sformatf("vec%0d", i));
      end

      // Reset during E2 of STORE: control word drops at once, no write pulse.
      opcode   = 8'h01;
      run      = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      check("mid-store E2 c", 32'(bus.c), 32'h0800);
      #3;
      rst = 1'b0;
      #1;
      check("async reset c", 32'(bus.c), 32'd0);
      check("async reset alu_fn", 32'(bus.alu_fn), 32'd0);
      check("async reset instr_cnt", 32'(bus.instr_cnt), 32'd0);
      cnt_m = 0;
      @(negedge clk);
      rst = 1'b1;
      run = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("post-reset idle c", 32'(bus.c), 32'd0);
      end
      run = 1'b1;
      tick();

      // 17 NOPs on the 4-bit counter: 17 mod 16 = 1.
      for (int i = 0; i < 17; i++) exec(model(8'h00, 1'b0), 1'b1, $sformatf("nop%0d", i));
      check("wrap instr_cnt w4", 32'(bus4.instr_cnt), 32'd1);

      for (int i = 0; i < 300; i++) begin
         op = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
         if (op == 8'h07) op = 8'h00;
         exec(model(op, 1'($urandom)), ($urandom_range(0, 3) != 0), $sformatf("rnd%0d op%h", i, op));
      end

      // HALT: fetch as usual, then terminal regardless of run.
      v        = model(8'h07, 1'b0);
      opcode   = 8'h07;
      run      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("halt fetch c[%0d]", i), 32'(bus.c), 32'(v.cw[i]));
         check($sformatf("halt fetch halted[%0d]", i), 32'(bus.halted), 32'd0);
         tick();
      end
      cnt_m++;
      for (int k = 0; k < 20; k++) begin
         run    = 1'($urandom);
         opcode = 8'($urandom);
         check($sformatf("halt halted[%0d]", k), 32'(bus.halted), 32'd1);
         check($sformatf("halt c[%0d]", k), 32'(bus.c), 32'd0);
         check($sformatf("halt alu_fn[%0d]", k), 32'(bus.alu_fn), 32'd0);
         check($sformatf("halt instr_cnt[%0d]", k), 32'(bus.instr_cnt), 32'(cnt_m % 65536));
         tick();
      end
      #2;
      rst = 1'b0;
      #1;
      check("halt exit halted", 32'(bus.halted), 32'd0);
      check("halt exit instr_cnt", 32'(bus.instr_cnt), 32'd0);

      check("c12 pulses", 32'(c12_seen), 32'(stores_m));
      check("c3 c15 overlap", 32'(overlap_seen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
